// File: rtl/jtdd_scan2x_if.sv
// Video bundle between a native-rate pixel source and the line doubler.
// Master drives native timing and pixels; slave returns the doubled stream.
// No handshake: timing is carried entirely by the pxl_cen / pxl2_cen enables.
interface jtdd_scan2x_if #(
  parameter int COLORW = 4
);
  localparam int PW = 3*COLORW;

  logic          pxl_cen;
  logic          pxl2_cen;
  logic          en;
  logic [PW-1:0] base_pxl;
  logic          HS;
  logic          LHBL;
  logic [PW-1:0] x2_pxl;
  logic          x2_HS;
  logic          x2_LHBL;

  modport master (
    output pxl_cen, pxl2_cen, en, base_pxl, HS, LHBL,
    input  x2_pxl, x2_HS, x2_LHBL
  );

  modport slave (
    input  pxl_cen, pxl2_cen, en, base_pxl, HS, LHBL,
    output x2_pxl, x2_HS, x2_LHBL
  );
endinterface

// File: rtl/jtdd_scan2x.sv
// Scan doubler: each native line is captured into one bank and replayed twice from the other bank.
// Latency: one native line plus one pxl2_cen in doubled mode; one pxl_cen in bypass.
// No backpressure: outputs update on pxl2_cen (doubled) or pxl_cen (bypass) and hold otherwise.
module jtdd_scan2x #(
  parameter int COLORW = 4,
  parameter int AW     = 9
) (
  input  logic         clk,
  input  logic         rst,
  jtdd_scan2x_if.slave vid
);
  localparam int PW = 3*COLORW;
  localparam int CW = AW+1;
  localparam logic [CW-1:0] CMAX = '1;
  localparam logic [AW-1:0] AMAX = '1;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CMAX) ? v : v + CW'(1);
  endfunction

  // Both banks in one array, addressed as {bank, addr}; contents are never reset.
  logic [PW-1:0] line_buf [0:(2**CW)-1];

  // Native side state
  logic          hs_l, lhbl_l;
  logic          wr_bank;
  logic [CW-1:0] wr_addr;        // MSB set means the bank is full and writes are dropped
  logic          line_ok;        // current line started on an HS rising edge
  logic [CW-1:0] cnt_q;          // position of the last native pixel within the line
  logic [CW-1:0] s_run, o_run, w_run;
  logic [CW-1:0] sh_l, sh_s, sh_o, sh_w;

  // Read side state
  logic [CW-1:0] rd_cnt;
  logic [PW-1:0] pxl_q;
  logic          hs_q, lhbl_q;

  // Combinational helpers
  logic          hs_rise, bank_cur, wr_en, line_vld, dbl_hs, dbl_lhbl;
  logic [CW-1:0] waddr_cur, pos, l_cur, s_cur, o_cur, w_cur, rd_pos, rd_ofs;
  logic [AW-1:0] rd_addr;
  logic [PW-1:0] rd_dat;

  // Line-start handling: a rising HS swaps banks, restarts counters and exposes the new shadow values
  // in the same cycle, so the read side never looks at the bank receiving pixels.
  always_comb begin
    hs_rise   = vid.pxl_cen & vid.HS & ~hs_l;
    bank_cur  = hs_rise ? ~wr_bank : wr_bank;
    waddr_cur = hs_rise ? '0 : wr_addr;
    pos       = hs_rise ? '0 : sat_inc(cnt_q);
    wr_en     = vid.pxl_cen & vid.LHBL & ~waddr_cur[AW];
    l_cur     = sh_l;
    s_cur     = sh_s;
    o_cur     = sh_o;
    w_cur     = sh_w;
    if (hs_rise) begin
      l_cur = line_ok ? sat_inc(cnt_q) : '0;
      s_cur = s_run;
      o_cur = o_run;
      w_cur = w_run;
    end
    rd_pos   = hs_rise ? '0 : rd_cnt;
    rd_ofs   = rd_pos - o_cur;
    rd_addr  = rd_ofs[AW] ? AMAX : rd_ofs[AW-1:0];
    rd_dat   = line_buf[{~bank_cur, rd_addr}];
    line_vld = (l_cur != '0);
    dbl_hs   = line_vld & (rd_pos < s_cur);
    dbl_lhbl = line_vld & ({1'b0, rd_pos} >= {1'b0, o_cur})
                        & ({1'b0, rd_pos} < ({1'b0, o_cur} + {1'b0, w_cur}));
  end

  // Line buffer write port
  always_ff @(posedge clk) begin
    if (!rst && wr_en) line_buf[{bank_cur, waddr_cur[AW-1:0]}] <= vid.base_pxl;
  end

  // Native-rate capture and line measurement, latched into the shadow set at each HS rising edge
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_l    <= 1'b0;
      lhbl_l  <= 1'b0;
      wr_bank <= 1'b0;
      wr_addr <= '0;
      line_ok <= 1'b0;
      cnt_q   <= '0;
      s_run   <= '0;
      o_run   <= '0;
      w_run   <= '0;
      sh_l    <= '0;
      sh_s    <= '0;
      sh_o    <= '0;
      sh_w    <= '0;
    end else if (vid.pxl_cen) begin
      hs_l    <= vid.HS;
      lhbl_l  <= vid.LHBL;
      wr_bank <= bank_cur;
      cnt_q   <= pos;
      wr_addr <= wr_en ? waddr_cur + CW'(1) : waddr_cur;
      if (hs_rise) begin
        s_run   <= {{(CW-1){1'b0}}, vid.HS};
        w_run   <= {{(CW-1){1'b0}}, vid.LHBL};
        o_run   <= '0;
        sh_l    <= l_cur;
        sh_s    <= s_cur;
        sh_o    <= o_cur;
        sh_w    <= w_cur;
        line_ok <= 1'b1;
      end else begin
        if (vid.HS)                 s_run <= sat_inc(s_run);
        if (vid.LHBL)               w_run <= sat_inc(w_run);
        if (vid.LHBL && !lhbl_l)    o_run <= pos;
      end
    end
  end

  // Double-rate read counter: wraps at the measured length so every line plays twice
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt <= '0;
    end else if (vid.pxl2_cen) begin
      rd_cnt <= (line_vld && rd_pos == l_cur - CW'(1)) ? '0 : sat_inc(rd_pos);
    end
  end

  // Output register: doubled stream on pxl2_cen, or native pass-through on pxl_cen
  always_ff @(posedge clk) begin
    if (rst) begin
      pxl_q  <= '0;
      hs_q   <= 1'b0;
      lhbl_q <= 1'b0;
    end else if (vid.en) begin
      if (vid.pxl2_cen) begin
        hs_q   <= dbl_hs;
        lhbl_q <= dbl_lhbl;
        pxl_q  <= dbl_lhbl ? rd_dat : '0;
      end
    end else if (vid.pxl_cen) begin
      hs_q   <= vid.HS;
      lhbl_q <= vid.LHBL;
      pxl_q  <= vid.LHBL ? vid.base_pxl : '0;
    end
  end

  assign vid.x2_pxl  = pxl_q;
  assign vid.x2_HS   = hs_q;
  assign vid.x2_LHBL = lhbl_q;
endmodule

// File: tb/tb_jtdd_scan2x.sv
// Bench for jtdd_scan2x: drives native lines (pxl_cen every 4 clocks, pxl2_cen every 2) and compares
// every output sample with a line-level reference model plus per-line aggregate counts.
module tb_jtdd_scan2x;
  localparam int COLORW = 4;
  localparam int AW     = 9;
  localparam int PW     = 3*COLORW;
  localparam int DEPTH  = 2**AW;
  localparam int CMAX   = 2**(AW+1) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jtdd_scan2x_if #(.COLORW(COLORW)) vid();

  jtdd_scan2x #(.COLORW(COLORW), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .vid (vid)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: native samples of the line in progress, and the last completed line being replayed
  bit            m_prev_hs = 1'b0;
  bit            m_seen    = 1'b0;
  bit            cur_hs[$];
  bit            cur_lb[$];
  logic [PW-1:0] cur_pix[$];
  logic [PW-1:0] ply_pix[$];
  int            ply_l = 0, ply_s = 0, ply_o = 0, ply_w = 0;
  int            t_now = 0, t_start = 0;
  logic [PW+1:0] exp_out = '0;

  // Aggregates over the output samples of one native line
  int a_hs, a_lb, a_nz, a_ramp_err, a_v0f0, a_vf00, a_v511, a_lbidx;

  task automatic clr_agg();
    a_hs = 0; a_lb = 0; a_nz = 0; a_ramp_err = 0;
    a_v0f0 = 0; a_vf00 = 0; a_v511 = 0; a_lbidx = 0;
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic finish_line();
    int s, o, w;
    s = 0; o = 0; w = 0;
    foreach (cur_hs[i]) begin
      if (cur_hs[i]) s++;
      if (cur_lb[i]) w++;
      if (i > 0 && cur_lb[i] && !cur_lb[i-1]) o = i;
    end
    ply_l   = m_seen ? sat(cur_hs.size()) : 0;
    ply_s   = sat(s);
    ply_o   = o;
    ply_w   = sat(w);
    ply_pix = cur_pix;
  endtask

  function automatic logic [PW+1:0] doubled_out(input int t);
    int p, a;
    bit h, b;
    logic [PW-1:0] px;
    if (ply_l == 0) return '0;
    p  = (t - t_start) % ply_l;
    h  = (p < ply_s);
    b  = (p >= ply_o) && (p < ply_o + ply_w);
    a  = p - ply_o;
    if (a > DEPTH-1) a = DEPTH-1;
    px = '0;
    if (b && a >= 0 && a < ply_pix.size()) px = ply_pix[a];
    return {px, h, b};
  endfunction

  task automatic cyc(input bit pc, input bit p2);
    logic [PW+1:0] act;
    vid.pxl_cen  = pc;
    vid.pxl2_cen = p2;
    if (rst) begin
      m_prev_hs = 1'b0;
      m_seen    = 1'b0;
      cur_hs.delete(); cur_lb.delete(); cur_pix.delete(); ply_pix.delete();
      ply_l   = 0;
      exp_out = '0;
      clr_agg();
    end else begin
      if (pc) begin
        if (vid.HS && !m_prev_hs) begin
          finish_line();
          m_seen  = 1'b1;
          t_start = t_now;
          cur_hs.delete(); cur_lb.delete(); cur_pix.delete();
        end
        m_prev_hs = vid.HS;
        cur_hs.push_back(vid.HS);
        cur_lb.push_back(vid.LHBL);
        if (vid.LHBL && cur_pix.size() < DEPTH) cur_pix.push_back(vid.base_pxl);
      end
      if (vid.en && p2)
        exp_out = doubled_out(t_now);
      else if (!vid.en && pc)
        exp_out = {(vid.LHBL ? vid.base_pxl : {PW{1'b0}}), vid.HS, vid.LHBL};
    end
    if (p2) t_now++;
    @(posedge clk);
    #1;
    act = {vid.x2_pxl, vid.x2_HS, vid.x2_LHBL};
    chk("x2_out", 32'(act), 32'(exp_out));
    if (act != '0) a_nz++;
    if (p2 && vid.en && !rst) begin
      if (vid.x2_HS) a_hs++;
      if (vid.x2_LHBL) begin
        a_lb++;
        if (vid.x2_pxl != PW'(a_lbidx % 256)) a_ramp_err++;
        a_lbidx++;
        if (vid.x2_pxl == 12'h0F0) a_v0f0++;
        if (vid.x2_pxl == 12'hF00) a_vf00++;
        if (vid.x2_pxl == 12'd511) a_v511++;
      end
    end
  endtask

  // mode 0: ramp from 0 across the active window, 1: constant cval, 2: random
  task automatic drive_line(input int l, input int s, input int o, input int w,
                            input int mode, input logic [PW-1:0] cval,
                            input int rst_pos, input int en_pos);
    for (int p = 0; p < l; p++) begin
      vid.HS   = (p < s);
      vid.LHBL = (p >= o) && (p < o + w);
      if (p == en_pos) vid.en = 1'b1;
      case (mode)
        0:       vid.base_pxl = vid.LHBL ? PW'(p - o) : PW'($urandom);
        1:       vid.base_pxl = cval;
        default: vid.base_pxl = PW'($urandom);
      endcase
      for (int c = 0; c < 4; c++) begin
        rst = (p == rst_pos) && (c < 3);
        cyc(c == 0, (c == 0) || (c == 2));
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    int l, s, o, w;
    vid.pxl_cen  = 1'b0;
    vid.pxl2_cen = 1'b0;
    vid.en       = 1'b1;
    vid.base_pxl = '0;
    vid.HS       = 1'b0;
    vid.LHBL     = 1'b0;
    clr_agg();

    // Power-on reset
    rst = 1'b1;
    for (int i = 0; i < 3; i++) cyc(i == 0, (i % 2) == 0);
    chk("rst_pxl",  32'(vid.x2_pxl), 32'd0);
    chk("rst_hs",   32'(vid.x2_HS), 32'd0);
    chk("rst_lhbl", 32'(vid.x2_LHBL), 32'd0);
    rst = 1'b0;

    // Reset during active video, then silence until the second HS rising edge
    drive_line(384, 32, 64, 256, 0, '0, -1, -1);
    drive_line(384, 32, 64, 256, 0, '0, 100, -1);
    drive_line(384, 32, 64, 256, 0, '0, -1, -1);
    chk("post_rst_quiet", 32'(a_nz), 32'd0);

    // Steady ramp lines
    drive_line(384, 32, 64, 256, 0, '0, -1, -1);
    drive_line(384, 32, 64, 256, 0, '0, -1, -1);
    clr_agg();
    drive_line(384, 32, 64, 256, 0, '0, -1, -1);
    chk("ramp_hs_cnt",   32'(a_hs), 32'd64);
    chk("ramp_lhbl_cnt", 32'(a_lb), 32'd512);
    chk("ramp_order",    32'(a_ramp_err), 32'd0);

    // Bank isolation
    drive_line(384, 32, 64, 256, 1, 12'hF00, -1, -1);
    clr_agg();
    drive_line(384, 32, 64, 256, 1, 12'h0F0, -1, -1);
    chk("bank_no_new", 32'(a_v0f0), 32'd0);
    chk("bank_old",    32'(a_vf00), 32'd512);

    // Overflow of the line buffer
    drive_line(700, 32, 64, 600, 0, '0, -1, -1);
    clr_agg();
    drive_line(700, 32, 64, 600, 0, '0, -1, -1);
    chk("ovf_lhbl_cnt", 32'(a_lb), 32'd1200);
    chk("ovf_clamp",    32'(a_v511), 32'd178);

    // Short line truncates the repeat
    drive_line(384, 32, 64, 256, 0, '0, -1, -1);
    drive_line(300, 32, 64, 256, 0, '0, -1, -1);
    clr_agg();
    drive_line(384, 32, 64, 256, 0, '0, -1, -1);
    chk("short_hs_cnt",   32'(a_hs), 32'd96);
    chk("short_lhbl_cnt", 32'(a_lb), 32'd576);

    // Bypass, then switch to doubling mid-line
    vid.en = 1'b0;
    drive_line(256, 20, 40, 180, 2, '0, -1, -1);
    drive_line(256, 20, 40, 180, 2, '0, -1, -1);
    drive_line(384, 32, 64, 256, 0, '0, -1, 150);
    clr_agg();
    drive_line(384, 32, 64, 256, 2, '0, -1, -1);
    chk("en_switch_lhbl", 32'(a_lb), 32'd512);
    chk("en_switch_ramp", 32'(a_ramp_err), 32'd0);

    // Random geometry and content, one with a mid-line reset
    for (int k = 0; k < 5; k++) begin
      l = int'($urandom_range(200, 500));
      s = int'($urandom_range(8, 40));
      o = int'($urandom_range(s, 100));
      w = int'($urandom_range(50, l - o));
      drive_line(l, s, o, w, 2, '0, (k == 2) ? int'($urandom_range(o, l - 1)) : -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
